// File: rtl/mult_pkg.sv
// Shared definitions for the 3x2 multiplier and its downstream accumulator.
package mult_pkg;

    localparam int unsigned A_W      = 3;
    localparam int unsigned B_W      = 2;
    localparam int unsigned PROD_W   = 5;
    localparam int unsigned PROD_MAX = 21;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums a frame of COUNT multiplier products and presents the frame sum
// with a sticky overflow flag on a valid/ready output handshake.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned COUNT = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] q,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);

    acc_state_t        state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              acc_ovf, acc_ovf_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ACC_W-1:0]  sum_nxt;
    logic              ovf_nxt;
    logic              out_valid_nxt;
    logic [ACC_W:0]    add_full;
    logic              last;

    // Ready is a pure state decode, held low while reset is asserted.
    assign in_ready = (state == ACCUM) && !rst;

    // The accept that brings the counter to COUNT closes the frame.
    assign last = (cnt == CNT_W'(COUNT - 1));

    // State and datapath registers; synchronous reset clears the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            acc_ovf   <= acc_ovf_nxt;
            cnt       <= cnt_nxt;
            sum       <= sum_nxt;
            ovf       <= ovf_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state and datapath update for accumulate / hold-result phases.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        acc_ovf_nxt   = acc_ovf;
        cnt_nxt       = cnt;
        sum_nxt       = sum;
        ovf_nxt       = ovf;
        out_valid_nxt = out_valid;
        add_full      = {1'b0, acc} + (ACC_W + 1)'(q);

        case (state)
            ACCUM: begin
                if (in_valid) begin
                    acc_nxt     = add_full[ACC_W-1:0];
                    acc_ovf_nxt = acc_ovf | add_full[ACC_W];
                    cnt_nxt     = cnt + CNT_W'(1);
                    if (last) begin
                        state_nxt     = DONE;
                        sum_nxt       = add_full[ACC_W-1:0];
                        ovf_nxt       = acc_ovf | add_full[ACC_W];
                        out_valid_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                // Result held until taken; the next frame starts clean.
                if (out_ready) begin
                    state_nxt     = ACCUM;
                    out_valid_nxt = 1'b0;
                    acc_nxt       = '0;
                    acc_ovf_nxt   = 1'b0;
                    cnt_nxt       = '0;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 3x2 multiplier's 5-bit product. It accepts one product per valid/ready handshake and sums a frame of `COUNT` products into an `ACC_W`-bit accumulator. It then presents the frame sum, with an overflow flag, on an output valid/ready handshake. This block forms the sequential dot-product / MAC stage that follows the combinational multiplier.

## Interface
Parameters:
- `COUNT`, default 4: number of products per frame. Legal range 2..255.
- `ACC_W`, default 8: accumulator and sum width. Legal range 5..16.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `q`  in  5: product from the multiplier, unsigned, 0..21.
- `in_valid`  in  1: `q` is valid this cycle.
- `in_ready`  out  1: the block accepts `q` this cycle.
- `sum`  out  ACC_W: frame sum, modulo 2^ACC_W.
- `ovf`  out  1: at least one carry out of bit ACC_W-1 occurred during the frame.
- `out_valid`  out  1: `sum` and `ovf` are valid.
- `out_ready`  in  1: the downstream stage takes `sum` this cycle.

## Operation
- States:
  - `ACCUM`: accepting products.
  - `DONE`: holding the result.
- Reset action, with `rst`=1 at a clock edge:
  - state goes to `ACCUM`.
  - internal accumulator = 0.
  - frame counter = 0.
  - `sum` = 0, `ovf` = 0, `out_valid` = 0.
- While `rst`=1, `in_ready` = 0. Reset mid-frame discards the partial sum and count. No output is produced for that frame.
- `ACCUM` behaviour:
  - `in_ready` = 1, `out_valid` = 0.
  - Accept condition: `in_valid` and `in_ready`.
  - On accept: accumulator += zero-extended `q`, modulo 2^ACC_W. Any carry out sets the sticky overflow. The counter increments.
  - Cycles with `in_valid`=0 change nothing, so bubbles are allowed anywhere.
- `ACCUM` to `DONE`: on the accept that makes the counter equal `COUNT`. That same edge registers the final sum (including this product) into `sum`/`ovf` and sets `out_valid` = 1.
- `DONE` behaviour:
  - `in_ready` = 0. `q` and `in_valid` are ignored.
  - `sum`, `ovf` and `out_valid` stay stable until `out_ready` = 1.
- `DONE` to `ACCUM`: on `out_valid` and `out_ready`. At that edge:
  - `out_valid` goes to 0.
  - accumulator, counter and overflow clear to 0.
  - `sum`/`ovf` keep their last value; they are don't-care while `out_valid` = 0.
- There is no input bypass while in `DONE`. A product offered in that cycle is not taken; the upstream stage holds it.
- Width rule: `ovf` is 0 whenever COUNT*21 < 2^ACC_W.
- `q` values above 21 are outside the multiplier's range but are still summed as unsigned.

## Timing
- `in_ready` and `out_valid` are registered-state decodes. Neither depends combinationally on `in_valid` or `out_ready`.
- Latency: `out_valid` rises 1 cycle after the edge that accepts the COUNT-th product.
- Throughput: COUNT+1 cycles per frame minimum, with continuous `in_valid` and `out_ready` held at 1.
- First accept after reset: the first edge with `rst`=0 and `in_valid`=1.
- After the output handshake, `in_ready` = 1 in the next cycle.

## Structure
- Shared package `mult_pkg`:
  - `PROD_W` = 5 and `PROD_MAX` = 21.
  - Operand widths 3 and 2.
  - State enum {`ACCUM`, `DONE`}.
- Single module. No sub-module is needed.
- The counter width is $clog2(COUNT+1), computed locally.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Reset, then COUNT=4, ACC_W=8, feed q = 21, 21, 21, 21 back-to-back with `out_ready`=1:
  - sum = 84, ovf = 0.
  - `out_valid` high 1 cycle after the 4th accept.
  - Next frame accepted 1 cycle later.
- ACC_W=6, same stimulus: sum = 20 (84 mod 64), ovf = 1.
- Feed q = 3, 0, 6, 2 with `in_valid` bubbles between items: sum = 11. Result timing is set only by the 4th accept.
- Backpressure: hold `out_ready`=0 for 5 cycles in `DONE` while driving `in_valid`=1, q=9:
  - `sum`/`ovf`/`out_valid` stay stable.
  - `in_ready` = 0 throughout.
  - Once `out_ready`=1, the next frame's first accepted q is 9.
- Reset mid-frame: accept q = 7, 7, assert `rst` for 1 cycle, then feed 1, 2, 3, 4:
  - sum = 10, ovf = 0.
  - No `out_valid` for the aborted frame.
- Reset asserted in `DONE`: `out_valid` = 0 at the next edge. `in_ready` = 1 once `rst` drops.
